// File: rtl/qspi_pkg.sv
// Protocol constants and FSM states shared by both ends of the QSPI quad-read link.
package qspi_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_IGNORE
  } qspi_state_e;

  localparam logic [7:0] QSPI_CMD_QUAD_READ = 8'hEB;
  localparam int         QSPI_ADDR_BITS     = 24;
  localparam int         QSPI_MODE_CYCLES   = 2;
  localparam int         QSPI_DUMMY_CYCLES  = 4;
endpackage

// File: rtl/qspi_rom_responder_if.sv
// QSPI pin bundle between flash controller (master) and ROM responder (slave).
interface qspi_rom_responder_if;
  logic       spi_select;
  logic       spi_clk;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;

  modport master (output spi_select, spi_clk, spi_data_in,
                  input  spi_data_out, spi_data_oe);
  modport slave  (input  spi_select, spi_clk, spi_data_in,
                  output spi_data_out, spi_data_oe);
endinterface

// File: rtl/qspi_edge_detect.sv
// Registers SCK and emits one-clk rise/fall strobes; strobes are registered so
// responder outputs land 2 clk after the SCK edge.
module qspi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  output logic rise,
  output logic fall
);
  logic sck_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sck_q <= sck;
      rise  <= sck & ~sck_q;
      fall  <= ~sck & sck_q;
    end
  end
endmodule

// File: rtl/qspi_rom_responder.sv
// QSPI flash responder: serves 0xEB quad-I/O fast reads from an external
// byte-wide memory port with 1-clk read latency.
module qspi_rom_responder
  import qspi_pkg::*;
#(
  parameter int         ADDR_BITS    = QSPI_ADDR_BITS,
  parameter logic [7:0] CMD_BYTE     = QSPI_CMD_QUAD_READ,
  parameter int         MODE_CYCLES  = QSPI_MODE_CYCLES,
  parameter int         DUMMY_CYCLES = QSPI_DUMMY_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qspi_rom_responder_if.slave  spi,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_data,
  output logic                 busy
);
  localparam logic [7:0] CMD_LAST   = 8'd7;
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS/4 - 1);
  localparam logic [7:0] MODE_LAST  = 8'(MODE_CYCLES - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  qspi_state_e          state, state_nxt;
  logic                 rise, fall, sel, armed, rd_pend, nib_lo;
  logic [7:0]           cnt, byte_buf;
  logic [6:0]           cmd_sr;
  logic [3:0]           lo_nib, sd;
  logic [ADDR_BITS-1:0] addr;

  assign sel  = spi.spi_select;
  assign sd   = spi.spi_data_in;
  assign busy = ~sel & (state != ST_IDLE);

  qspi_edge_detect u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sck  (spi.spi_clk),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (armed) state_nxt = ST_CMD;
      ST_CMD:   if (rise && cnt == CMD_LAST)
                  state_nxt = ({cmd_sr, sd[0]} == CMD_BYTE) ? ST_ADDR : ST_IGNORE;
      ST_ADDR:  if (rise && cnt == ADDR_LAST)  state_nxt = ST_MODE;
      ST_MODE:  if (rise && cnt == MODE_LAST)  state_nxt = ST_DUMMY;
      ST_DUMMY: if (rise && cnt == DUMMY_LAST) state_nxt = ST_DATA;
      default:  ;
    endcase
    // deselect overrides any same-cycle SCK sample
    if (sel) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi.spi_data_out <= '0;
      spi.spi_data_oe  <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      armed    <= 1'b0;
      rd_pend  <= 1'b0;
      nib_lo   <= 1'b0;
      cnt      <= '0;
      cmd_sr   <= '0;
      addr     <= '0;
      byte_buf <= '0;
      lo_nib   <= '0;
    end else begin
      mem_rd  <= 1'b0;
      rd_pend <= mem_rd & ~sel;
      if (rd_pend && !sel) byte_buf <= mem_data;
      if (sel) begin
        // a new transaction only starts after a high->low select after reset
        armed           <= 1'b1;
        spi.spi_data_oe <= '0;
        rd_pend         <= 1'b0;
        nib_lo          <= 1'b0;
        cnt             <= '0;
        addr            <= '0;
      end else begin
        if (state_nxt != state) cnt <= '0;
        else if (rise)          cnt <= cnt + 8'd1;
        case (state)
          ST_CMD:  if (rise) cmd_sr <= {cmd_sr[5:0], sd[0]};
          ST_ADDR: if (rise) addr <= {addr[ADDR_BITS-5:0], sd};
          ST_MODE: if (rise && cnt == MODE_LAST) begin
            mem_rd   <= 1'b1;
            mem_addr <= addr;
          end
          ST_DATA: if (fall) begin
            spi.spi_data_oe <= 4'hF;
            nib_lo          <= ~nib_lo;
            if (!nib_lo) begin
              // keep the low nibble; byte_buf is refilled by the next prefetch
              spi.spi_data_out <= byte_buf[7:4];
              lo_nib           <= byte_buf[3:0];
              addr             <= addr + ADDR_BITS'(1);
              mem_addr         <= addr + ADDR_BITS'(1);
              mem_rd           <= 1'b1;
            end else begin
              spi.spi_data_out <= lo_nib;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qspi_rom_responder.sv
// Directed bench: table of 2-byte reads plus hand-written corner sequences.
module tb_qspi_rom_responder;
  import qspi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic        busy;
  logic [7:0]  mem_key = 8'h00;
  logic [23:0] rd_log[$];

  always #5 clk = ~clk;

  qspi_rom_responder_if spi();

  qspi_rom_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi     (spi.slave),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .mem_data(mem_data),
    .busy    (busy)
  );

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_addr[7:0] ^ mem_key;
      rd_log.push_back(mem_addr);
    end
  end

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
  } vec_t;

  int   hp = 3;
  int   checks = 0;
  int   passes = 0;
  logic [7:0] rx[32];
  logic hdr_oe_bad, dat_oe_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    spi.spi_data_in = d;
    repeat (hp) @(negedge clk);
    q  = spi.spi_data_out;
    oe = spi.spi_data_oe;
    spi.spi_clk = 1'b1;
    repeat (hp) @(negedge clk);
    spi.spi_clk = 1'b0;
  endtask

  task automatic start_tx();
    spi.spi_select = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_tx();
    spi.spi_select = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] q, oe;
    for (int i = 0; i < 8; i++) begin
      sck_cycle({3'b000, c[7-i]}, q, oe);
      if (oe !== 4'h0) hdr_oe_bad = 1'b1;
    end
  endtask

  task automatic send_addr(input logic [23:0] a, input int nibs);
    logic [3:0] q, oe;
    for (int i = 0; i < nibs; i++) begin
      sck_cycle(a[23-4*i -: 4], q, oe);
      if (oe !== 4'h0) hdr_oe_bad = 1'b1;
    end
  endtask

  task automatic read_tx(input logic [23:0] a, input int n, input bit hold);
    logic [3:0] hi, lo, oe;
    hdr_oe_bad = 1'b0;
    dat_oe_bad = 1'b0;
    start_tx();
    send_cmd(QSPI_CMD_QUAD_READ);
    send_addr(a, 6);
    for (int i = 0; i < QSPI_MODE_CYCLES + QSPI_DUMMY_CYCLES; i++) begin
      sck_cycle(4'hA, hi, oe);
      if (oe !== 4'h0) hdr_oe_bad = 1'b1;
    end
    for (int b = 0; b < n; b++) begin
      sck_cycle(4'h0, hi, oe);
      if (oe !== 4'hF) dat_oe_bad = 1'b1;
      sck_cycle(4'h0, lo, oe);
      if (oe !== 4'hF) dat_oe_bad = 1'b1;
      rx[b] = {hi, lo};
    end
    if (!hold) end_tx();
  endtask

  initial begin
    vec_t vecs[5];
    logic [3:0] q, oe;
    logic [23:0] ea;
    int n0;

    vecs[0] = '{24'h00_0000, 8'h00, 8'h01};
    vecs[1] = '{24'h12_34FF, 8'hFF, 8'h00};
    vecs[2] = '{24'hAB_CD80, 8'h80, 8'h81};
    vecs[3] = '{24'h10_007E, 8'h7E, 8'h7F};
    vecs[4] = '{24'h5A_5A10, 8'h10, 8'h11};

    spi.spi_select  = 1'b1;
    spi.spi_clk     = 1'b0;
    spi.spi_data_in = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_oe",   {28'd0, spi.spi_data_oe},  32'h0);
    chk("rst_dout", {28'd0, spi.spi_data_out}, 32'h0);
    chk("rst_rd",   {31'd0, mem_rd},           32'h0);
    chk("rst_addr", {8'd0, mem_addr},          32'h0);
    chk("rst_busy", {31'd0, busy},             32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // four-byte read, high nibble first
    read_tx(24'h10_0123, 4, 1'b0);
    for (int b = 0; b < 4; b++) chk($sformatf("rd4_b%0d", b), {24'd0, rx[b]}, 32'h23 + b);
    chk("rd4_hdr_oe", {31'd0, hdr_oe_bad}, 32'h0);
    chk("rd4_dat_oe", {31'd0, dat_oe_bad}, 32'h0);
    chk("rd4_oe_after", {28'd0, spi.spi_data_oe}, 32'h0);

    for (int v = 0; v < 5; v++) begin
      read_tx(vecs[v].addr, 2, 1'b0);
      chk($sformatf("vec%0d_b0", v), {24'd0, rx[0]}, {24'd0, vecs[v].exp0});
      chk($sformatf("vec%0d_b1", v), {24'd0, rx[1]}, {24'd0, vecs[v].exp1});
      chk($sformatf("vec%0d_oe", v), {30'd0, hdr_oe_bad, dat_oe_bad}, 32'h0);
    end

    // unsupported command is ignored for the rest of the select window
    n0 = rd_log.size();
    hdr_oe_bad = 1'b0;
    start_tx();
    send_cmd(8'h03);
    for (int i = 0; i < 32; i++) begin
      sck_cycle(4'hF, q, oe);
      if (oe !== 4'h0) hdr_oe_bad = 1'b1;
    end
    chk("ign_busy", {31'd0, busy}, 32'h1);
    end_tx();
    chk("ign_oe",  {31'd0, hdr_oe_bad}, 32'h0);
    chk("ign_rds", rd_log.size() - n0, 32'h0);

    // abort mid-address, then a clean read of 0
    start_tx();
    send_cmd(QSPI_CMD_QUAD_READ);
    send_addr(24'h12_3456, 3);
    end_tx();
    read_tx(24'h00_0000, 1, 1'b0);
    chk("abort_b0", {24'd0, rx[0]}, 32'h00);

    // address wrap
    rd_log.delete();
    read_tx(24'hFF_FFFF, 2, 1'b0);
    chk("wrap_rd0", {8'd0, rd_log.size() > 0 ? rd_log[0] : 24'hxxxxxx}, 32'hFF_FFFF);
    chk("wrap_rd1", {8'd0, rd_log.size() > 1 ? rd_log[1] : 24'hxxxxxx}, 32'h00_0000);
    chk("wrap_b0", {24'd0, rx[0]}, 32'hFF);
    chk("wrap_b1", {24'd0, rx[1]}, 32'h00);

    // reset pulse during DATA
    read_tx(24'h10_0123, 1, 1'b1);
    repeat (3) @(negedge clk);
    chk("rstd_oe_pre", {28'd0, spi.spi_data_oe}, 32'hF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstd_oe",   {28'd0, spi.spi_data_oe}, 32'h0);
    chk("rstd_busy", {31'd0, busy},            32'h0);
    repeat (4) @(negedge clk);
    chk("rstd_unarmed", {31'd0, busy}, 32'h0);
    end_tx();
    read_tx(24'h10_0000, 2, 1'b0);
    chk("rstd_b0", {24'd0, rx[0]}, 32'h00);
    chk("rstd_b1", {24'd0, rx[1]}, 32'h01);

    // fastest SCK, back-to-back 16-byte reads with a scrambled memory image
    hp = 2;
    mem_key = 8'hA5;
    read_tx(24'h00_1230, 16, 1'b0);
    for (int b = 0; b < 16; b++) begin
      ea = 24'h00_1230 + 24'(b);
      chk($sformatf("fast0_b%0d", b), {24'd0, rx[b]}, {24'd0, ea[7:0] ^ 8'hA5});
    end
    read_tx(24'hFF_FFF8, 16, 1'b0);
    for (int b = 0; b < 16; b++) begin
      ea = 24'hFF_FFF8 + 24'(b);
      chk($sformatf("fast1_b%0d", b), {24'd0, rx[b]}, {24'd0, ea[7:0] ^ 8'hA5});
    end
    chk("fast_oe", {30'd0, hdr_oe_bad, dat_oe_bad}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/qspi_rom_responder.md
# qspi_rom_responder

Synthesizable QSPI flash responder that serves cartridge ROM bytes from an on-chip or board-side memory port. It emulates the quad-I/O fast-read sequence issued by `qspi_flash_controller` (command 0xEB), so the console can run on FPGA builds without a physical flash PMOD. It also lets the full ROM-fetch path be verified end-to-end in simulation. It sits on the other end of the `uio` QSPI pins and is sampled with the system clock.

## Interface
- `ADDR_BITS`, 24: flash address width. The address counter wraps at 2^ADDR_BITS.
- `CMD_BYTE`, 8'hEB: the only accepted command.
- `MODE_CYCLES`, 2: SCK cycles for the mode byte, which is ignored.
- `DUMMY_CYCLES`, 4: SCK cycles between the mode byte and the first data nibble.
- `clk`  in  1: system clock. SCK half-period must be ≥ 2 `clk`.
- `rst_n`  in  1: synchronous, active-low reset.
- `spi_select`  in  1: chip select, active low.
- `spi_clk`  in  1: SCK from the controller, synchronous to `clk`.
- `spi_data_in`  in  4: SD3..SD0 as driven by the controller.
- `spi_data_out`  out  4: nibble driven back to the controller.
- `spi_data_oe`  out  4: output enables. Either all four lines are driven or none.
- `mem_addr`  out  ADDR_BITS: memory read address.
- `mem_rd`  out  1: one-cycle read strobe.
- `mem_data`  in  8: read data, valid exactly 1 `clk` after `mem_rd`.
- `busy`  out  1: high while `spi_select` is low and the state is not IDLE.

## Operation
- Edge detection: register `spi_clk` as `sck_q`.
  - `rise` = `spi_clk & ~sck_q`.
  - `fall` = `~spi_clk & sck_q`.
  - All protocol inputs are sampled on `rise`. All outputs change on `fall`.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
  - IDLE → CMD when `spi_select` is low. Clear the bit counter.
  - CMD: on each `rise`, shift in SD0, MSB first. After 8 bits, go to ADDR if the byte equals `CMD_BYTE`, otherwise go to IGNORE.
  - ADDR: on each `rise`, shift in a nibble {SD3..SD0}, MSB nibble first. After ADDR_BITS/4 nibbles, latch the address and go to MODE.
  - MODE: count `MODE_CYCLES` rises, then go to DUMMY. On entry to DUMMY, pulse `mem_rd` with the latched address.
  - DUMMY: count `DUMMY_CYCLES` rises, then go to DATA. The prefetched byte is already held in `byte_buf`.
  - DATA, two nibbles per byte:
    - On the `fall` that starts the high nibble, drive `byte_buf[7:4]` and pulse `mem_rd` for address+1.
    - On the next `fall`, drive `byte_buf[3:0]`.
    - On the `fall` after that, load the new `mem_data` into `byte_buf` and drive its high nibble.
    - The address increments modulo 2^ADDR_BITS.
  - IGNORE: outputs stay released until `spi_select` goes high.
- `spi_select` high in any state:
  - Next `clk`: state becomes IDLE, `spi_data_oe` = 0, counters clear.
  - A pending `mem_rd` result is discarded.
- `spi_data_oe` = 4'hF only in DATA, from the first data `fall` until deselect. It is 0 in every other state.
- A mode byte with continuous-read bits set is not honoured. Every transaction must resend the command.

## Timing
- Reset values: `spi_data_out` = 0, `spi_data_oe` = 0, `mem_rd` = 0, `mem_addr` = 0, `busy` = 0, state = IDLE.
- Reset mid-transaction behaves like deselect. The next command is accepted only after `spi_select` goes high and then low again.
- Edge latency: outputs update 1 `clk` after the `fall` is visible in `sck_q`, so 2 `clk` after the SCK edge. This is why the SCK half-period must be ≥ 2 `clk`.
- `mem_rd` occurs at least 3 `clk` before its data is driven, which satisfies the 1-cycle memory latency with margin.
- Simultaneous `rise` and deselect: deselect wins and the sample is dropped.
- Transaction length on SCK: 8 + ADDR_BITS/4 + `MODE_CYCLES` + `DUMMY_CYCLES` SCK cycles, then 2 per byte. With default parameters this is 20 SCK cycles before the first data nibble.

## Structure
- Shared package `qspi_pkg`:
  - state enum;
  - `QSPI_CMD_QUAD_READ` = 8'hEB;
  - default mode and dummy cycle counts.
- This package is shared with `qspi_flash_controller` so both ends agree on the protocol.
- One sub-module, `qspi_edge_detect`: registers SCK and produces `rise` and `fall`.
- Memory is external to the block. The FPGA wrapper binds it to a `$readmemh` array loaded at the `4'b0001` bank offset.

## Test plan
- Read from 0x10_0123, memory = address[7:0]: bytes 0x23, 0x24, 0x25, 0x26 are returned, high nibble first, `oe` = 4'hF only during data.
- Command 0x03: state is IGNORE, `oe` stays 0 for 40 SCK cycles, and `mem_rd` never pulses.
- `spi_select` raised after 3 address nibbles, then a new 0xEB read of 0x00_0000: returns byte 0x00, with no leftover partial address.
- Read at 0xFF_FFFF for 2 bytes: `mem_addr` goes 0xFF_FFFF, then 0x00_0000.
- `rst_n` low for 1 `clk` during DATA: next `clk` has `oe` = 0 and `busy` = 0; a fresh read of 0x10_0000 then succeeds.
- Back-to-back reads with SCK half-period = 2 `clk`, compared against the controller model: all 16 bytes match the memory contents.
